// File: rtl/aes_sched_pkg.sv
// Shared types for the AES request scheduler.
//   aes_wire  : function/key-length enums, request and response structs, klen helper
//   aes_const : scheduler FSM state encoding
// Tags are carried at TagMaxW bits inside the structs so one package serves every
// TAGW instance; the scheduler zero-extends on entry and truncates on exit (TAGW <= TagMaxW).

package aes_wire;

  localparam int unsigned TagMaxW = 16;

  typedef enum logic [1:0] {
    FuncRsvd   = 2'd0,
    FuncKeyExp = 2'd1,
    FuncEnc    = 2'd2,
    FuncDec    = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    Klen128  = 2'd0,
    Klen192  = 2'd1,
    Klen256  = 2'd2,
    KlenRsvd = 2'd3
  } klen_e;

  typedef struct packed {
    func_e              func;
    klen_e              klen;
    logic [255:0]       key;
    logic [127:0]       data;
    logic [TagMaxW-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [127:0]       data;
    logic [TagMaxW-1:0] tag;
    logic               err;
  } rsp_t;

  // Reserved key length falls back to the longest key when it is not rejected.
  function automatic klen_e klen_issue(klen_e k);
    klen_e r;
    r = k;
    if (k == KlenRsvd) r = Klen256;
    return r;
  endfunction

endpackage

package aes_const;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/aes_sched_if.sv
// Bus bundle for aes_sched: request channel (valid/ready), round-core start/done
// channel and response channel (valid/ready).
//   slave  : scheduler view (consumes requests, drives the core, produces responses)
//   master : environment view (client plus round core)
// Parameter TAGW must match the scheduler instance.

interface aes_sched_if #(
  parameter int unsigned TAGW = 4
) ();

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_func;
  logic [1:0]      req_klen;
  logic [255:0]    req_key;
  logic [127:0]    req_data;
  logic [TAGW-1:0] req_tag;

  logic            core_start;
  logic [1:0]      core_func;
  logic [1:0]      core_klen;
  logic [255:0]    core_key;
  logic [127:0]    core_data;
  logic            core_done;
  logic [127:0]    core_result;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [127:0]    rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;

  modport slave (
    input  req_valid, req_func, req_klen, req_key, req_data, req_tag,
    input  core_done, core_result, rsp_ready,
    output req_ready, core_start, core_func, core_klen, core_key, core_data,
    output rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport master (
    output req_valid, req_func, req_klen, req_key, req_data, req_tag,
    output core_done, core_result, rsp_ready,
    input  req_ready, core_start, core_func, core_klen, core_key, core_data,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err
  );

endinterface

// File: rtl/aes_sched_fifo.sv
// Synchronous FIFO of an arbitrary entry type (request struct by default use).
// Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH, so full and empty
// are told apart by the extra MSB; count = wptr - rptr.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push_i, wdata_i   write request and data; ignored when full
//   pop_i, rdata_o    read request and head entry; pop ignored when empty
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries

module aes_sched_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  entry_t                   wdata_i,
  input  logic                     pop_i,
  output entry_t                   rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = DEPTH[AW:0];

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  entry_t      mem_q [DEPTH];
  logic        do_push, do_pop;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == FullCount);
  assign empty_o = (count_o == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/aes_sched.sv
// AES request scheduler. Queues key-expand / encrypt / decrypt requests, issues them
// one at a time to the shared round core and returns tagged responses in FIFO order.
// Ports:
//   clk, rst    clock, synchronous active-high reset (drops queued and in-flight work)
//   bus         aes_sched_if.slave: req_* in, core_* out/in, rsp_* out
//   key_valid   an expanded key is loaded in the round core
//   busy        FSM not idle or requests still queued
// Parameters: DEPTH (FIFO entries, power of two >= 2), TAGW (tag width, <= TagMaxW).
// Build option AES_SCHED_ERR_EN: when defined, reserved function, reserved key length on
// key expand, and encrypt/decrypt without a loaded key are answered with rsp_err=1 and
// never reach the core. When undefined, reserved function is dropped silently, reserved
// key length is issued as 256, and rsp_err is tied low.

module aes_sched
  import aes_wire::*;
  import aes_const::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  aes_sched_if.slave  bus,
  output logic        key_valid,
  output logic        busy
);

  state_e state_q, state_d;
  req_t   iss_q, iss_d;
  rsp_t   rsp_q, rsp_d;
  logic   kv_q, kv_d;
  klen_e  klen_st_q, klen_st_d;

  req_t                 fifo_wdata, fifo_rdata;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                 core_start;
  logic                 reject;

  // Request capture into the queue
  always_comb begin
    fifo_wdata                = '0;
    fifo_wdata.func           = func_e'(bus.req_func);
    fifo_wdata.klen           = klen_e'(bus.req_klen);
    fifo_wdata.key            = bus.req_key;
    fifo_wdata.data           = bus.req_data;
    fifo_wdata.tag[TAGW-1:0]  = bus.req_tag;
  end

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign fifo_push     = bus.req_valid & ~fifo_full;
  assign bus.req_ready = ~fifo_full;

  aes_sched_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    iss_d      = iss_q;
    rsp_d      = rsp_q;
    kv_d       = kv_q;
    klen_st_d  = klen_st_q;
    fifo_pop   = 1'b0;
    core_start = 1'b0;
    reject     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
`ifdef AES_SCHED_ERR_EN
          reject = (fifo_rdata.func == FuncRsvd) ||
                   ((fifo_rdata.func == FuncKeyExp) && (fifo_rdata.klen == KlenRsvd)) ||
                   (((fifo_rdata.func == FuncEnc) || (fifo_rdata.func == FuncDec)) && !kv_q);
`endif
          if (reject) begin
            // Core untouched, so its key state (and key_valid) is left as is.
            rsp_d     = '0;
            rsp_d.err = 1'b1;
            rsp_d.tag = fifo_rdata.tag;
            state_d   = StResp;
          end else if (fifo_rdata.func == FuncRsvd) begin
            // Dropped without a response.
            state_d = StIdle;
          end else begin
            iss_d = fifo_rdata;
            if (fifo_rdata.func == FuncKeyExp) begin
              iss_d.klen = klen_issue(fifo_rdata.klen);
              kv_d       = 1'b0;
            end else begin
              iss_d.klen = klen_st_q;
            end
            state_d = StIssue;
          end
        end
      end

      StIssue: begin
        core_start = 1'b1;
        state_d    = StWait;
      end

      StWait: begin
        if (bus.core_done) begin
          rsp_d     = '0;
          rsp_d.tag = iss_q.tag;
          if (iss_q.func == FuncKeyExp) begin
            kv_d      = 1'b1;
            klen_st_d = iss_q.klen;
          end else begin
            rsp_d.data = bus.core_result;
          end
          state_d = StResp;
        end
      end

      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      iss_q     <= '0;
      rsp_q     <= '0;
      kv_q      <= 1'b0;
      klen_st_q <= Klen128;
    end else begin
      state_q   <= state_d;
      iss_q     <= iss_d;
      rsp_q     <= rsp_d;
      kv_q      <= kv_d;
      klen_st_q <= klen_st_d;
    end
  end

  // Core side holds the issue register, stable from ISSUE through WAIT.
  assign bus.core_start = core_start;
  assign bus.core_func  = iss_q.func;
  assign bus.core_klen  = iss_q.klen;
  assign bus.core_key   = iss_q.key;
  assign bus.core_data  = iss_q.data;

  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_data  = rsp_q.data;
  assign bus.rsp_tag   = rsp_q.tag[TAGW-1:0];
`ifdef AES_SCHED_ERR_EN
  assign bus.rsp_err   = rsp_q.err;
`else
  assign bus.rsp_err   = 1'b0;
`endif

  assign key_valid = kv_q;
  assign busy      = (state_q != StIdle) | ~fifo_empty;

  // Upper tag bits and the occupancy count are intentionally not consumed.
  logic unused_bits;
  assign unused_bits = ^{rsp_q.tag, rsp_q.err, fifo_count};

endmodule

// File: tb/tb_aes_sched.sv
module tb_aes_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 4;

  logic clk = 1'b0;
  logic rst;
  logic key_valid, busy;

  aes_sched_if #(.TAGW(TAGW)) bus ();

  aes_sched #(
    .DEPTH (DEPTH),
    .TAGW  (TAGW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .key_valid (key_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: key loaded in core, and its length
  logic       m_kv;
  logic [1:0] m_klen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stand-in round core transform; any injective-ish mix of the inputs will do.
  function automatic logic [127:0] fake_core(input logic [1:0] f, input logic [255:0] k,
                                             input logic [127:0] d);
    return d ^ k[255:128] ^ k[127:0] ^ {126'd0, f};
  endfunction

  // Predicts the fate of one request given the key state at the time it is served.
  task automatic model_req(input logic [1:0] f, input logic [1:0] kl, output bit issue,
                           output bit rsp, output bit err, output logic [1:0] ckl);
`ifdef AES_SCHED_ERR_EN
    err   = (f == 2'd0) || (f == 2'd1 && kl == 2'd3) || (f >= 2'd2 && !m_kv);
    issue = !err;
    rsp   = 1'b1;
`else
    err   = 1'b0;
    issue = (f != 2'd0);
    rsp   = issue;
`endif
    ckl = (f == 2'd1) ? ((kl == 2'd3) ? 2'd2 : kl) : m_klen;
    if (issue && f == 2'd1) begin
      m_kv   = 1'b1;
      m_klen = ckl;
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid   = 1'b0;
    bus.req_func    = '0;
    bus.req_klen    = '0;
    bus.req_key     = '0;
    bus.req_data    = '0;
    bus.req_tag     = '0;
    bus.core_done   = 1'b0;
    bus.core_result = '0;
    bus.rsp_ready   = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst    = 1'b0;
    m_kv   = 1'b0;
    m_klen = 2'd0;
  endtask

  task automatic set_req(input logic [1:0] f, input logic [1:0] kl, input logic [255:0] k,
                         input logic [127:0] d, input logic [3:0] tag);
    bus.req_func = f;
    bus.req_klen = kl;
    bus.req_key  = k;
    bus.req_data = d;
    bus.req_tag  = tag;
  endtask

  // One-cycle push; returns in the cycle after the push edge.
  task automatic push_req(input logic [1:0] f, input logic [1:0] kl, input logic [255:0] k,
                          input logic [127:0] d, input logic [3:0] tag);
    set_req(f, kl, k, d, tag);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.core_start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Called in the core_start cycle; core_done lands lat cycles later.
  task automatic pulse_done(input int lat, input logic [127:0] res);
    repeat (lat) tick();
    bus.core_done   = 1'b1;
    bus.core_result = res;
    tick();
    bus.core_done   = 1'b0;
    bus.core_result = ~res;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, key_valid, busy, bus.core_start, bus.rsp_err}
        !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/rv/kv/busy/start/err=%b expected 100000",
               {bus.req_ready, bus.rsp_valid, key_valid, busy, bus.core_start, bus.rsp_err});
    end
    n_checks++;
    if ({bus.core_func, bus.core_klen, bus.core_key, bus.core_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_core_bus: got func=%0d klen=%0d key=%h data=%h expected all 0",
               bus.core_func, bus.core_klen, bus.core_key, bus.core_data);
    end
    n_checks++;
    if ({bus.rsp_data, bus.rsp_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got data=%h tag=%0d expected 0/0", bus.rsp_data, bus.rsp_tag);
    end
  endtask

  task automatic test_err_no_key();
    logic [255:0] k;
    logic [127:0] d;
    bit issue, rsp, err, ok;
    logic [1:0] ckl;
    int starts;
    apply_reset();
    k = {8{$urandom}};
    d = {4{$urandom}};
    model_req(2'd2, 2'd0, issue, rsp, err, ckl);
    push_req(2'd2, 2'd0, k, d, 4'd6);
    starts = bus.core_start ? 1 : 0;
    tick();  // cycle 2
    if (!issue) begin
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.core_start} !== 3'b110 || starts != 0) begin
        n_fail++;
        $display("FAIL err_cycle2: got valid/err/start=%b early_start=%0d expected 110/0",
                 {bus.rsp_valid, bus.rsp_err, bus.core_start}, starts);
      end
      n_checks++;
      if (bus.rsp_data !== 128'd0 || bus.rsp_tag !== 4'd6) begin
        n_fail++;
        $display("FAIL err_rsp: got data=%h tag=%0d expected 0/6", bus.rsp_data, bus.rsp_tag);
      end
      handshake();
      repeat (4) begin
        if (bus.core_start) starts++;
        tick();
      end
      n_checks++;
      if (starts != 0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_no_start: got starts=%0d busy=%b expected 0/0", starts, busy);
      end
    end else begin
      n_checks++;
      if (bus.core_start !== 1'b1 || bus.core_func !== 2'd2) begin
        n_fail++;
        $display("FAIL nokey_issue: got start=%b func=%0d expected 1/2",
                 bus.core_start, bus.core_func);
      end
      pulse_done(2, fake_core(2'd2, k, d));
      wait_rsp(ok);
      n_checks++;
      if (!ok || bus.rsp_err !== err || bus.rsp_data !== fake_core(2'd2, k, d) ||
          bus.rsp_tag !== 4'd6) begin
        n_fail++;
        $display("FAIL nokey_rsp: got ok=%0d err=%b data=%h tag=%0d expected 1/%b/%h/6",
                 ok, bus.rsp_err, bus.rsp_data, bus.rsp_tag, err, fake_core(2'd2, k, d));
      end
      handshake();
    end
  endtask

  task automatic test_key_expand();
    logic [255:0] k;
    bit issue, rsp, err;
    logic [1:0] ckl;
    int extra;
    k = {8{$urandom}};
    model_req(2'd1, 2'd0, issue, rsp, err, ckl);
    push_req(2'd1, 2'd0, k, 128'd0, 4'd3);  // cycle 1
    n_checks++;
    if (bus.core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL kexp_cycle1_start: got %b expected 0", bus.core_start);
    end
    tick();  // cycle 2
    n_checks++;
    if ({bus.core_start, bus.core_func, bus.core_klen} !== {1'b1, 2'd1, ckl} ||
        bus.core_key !== k) begin
      n_fail++;
      $display("FAIL kexp_issue: got start=%b func=%0d klen=%0d key=%h expected 1/1/%0d/%h",
               bus.core_start, bus.core_func, bus.core_klen, bus.core_key, ckl, k);
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.core_start) extra++;
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || extra != 0 || key_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL kexp_wait: got rsp_valid=%b extra_starts=%0d kv=%b expected 0/0/0",
               bus.rsp_valid, extra, key_valid);
    end
    bus.core_done   = 1'b1;
    bus.core_result = {4{$urandom}};
    tick();  // cycle 8
    bus.core_done = 1'b0;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_err, key_valid} !== {1'b1, 4'd3, 1'b0, m_kv} ||
        bus.rsp_data !== 128'd0) begin
      n_fail++;
      $display("FAIL kexp_rsp: got valid=%b tag=%0d err=%b kv=%b data=%h expected 1/3/0/%b/0",
               bus.rsp_valid, bus.rsp_tag, bus.rsp_err, key_valid, bus.rsp_data, m_kv);
    end
    handshake();
  endtask

  task automatic test_encrypt_stall();
    logic [255:0] k;
    logic [127:0] d, res;
    bit issue, rsp, err, ok;
    logic [1:0] ckl;
    k   = {8{$urandom}};
    d   = 128'h00112233445566778899aabbccddeeff;
    res = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    model_req(2'd2, 2'd0, issue, rsp, err, ckl);
    push_req(2'd2, 2'd0, k, d, 4'd5);
    wait_start(ok);
    n_checks++;
    if (!ok || bus.core_func !== 2'd2 || bus.core_klen !== ckl || bus.core_data !== d) begin
      n_fail++;
      $display("FAIL enc_issue: got ok=%0d func=%0d klen=%0d data=%h expected 1/2/%0d/%h",
               ok, bus.core_func, bus.core_klen, bus.core_data, ckl, d);
    end
    pulse_done(3, res);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_err} !== {1'b1, 4'd5, 1'b0} ||
          bus.rsp_data !== res) begin
        n_fail++;
        $display("FAIL enc_hold_%0d: got valid=%b tag=%0d err=%b data=%h expected 1/5/0/%h",
                 i, bus.rsp_valid, bus.rsp_tag, bus.rsp_err, bus.rsp_data, res);
      end
      if (i < 4) tick();
    end
    handshake();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL enc_after_ack: got rsp_valid=%b expected 0", bus.rsp_valid);
    end
  endtask

  task automatic test_fifo_full();
    logic [255:0] k;
    logic [127:0] bd;
    logic [127:0] d [DEPTH];
    bit issue, rsp, err, ok;
    logic [1:0] ckl;
    k  = {8{$urandom}};
    bd = {4{$urandom}};
    model_req(2'd2, 2'd0, issue, rsp, err, ckl);
    push_req(2'd2, 2'd0, k, bd, 4'd8);
    wait_start(ok);
    pulse_done(1, fake_core(2'd2, k, bd));
    // FSM now parked in RESP, so nothing drains the queue.
    for (int i = 0; i < DEPTH; i++) begin
      d[i] = {4{$urandom}};
      model_req(2'd3, 2'd0, issue, rsp, err, ckl);
      set_req(2'd3, 2'd0, k, d[i], 4'(i));
      bus.req_valid = 1'b1;
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_ready_%0d: got %b expected 1", i, bus.req_ready);
      end
      tick();
    end
    set_req(2'd3, 2'd0, k, {4{$urandom}}, 4'd9);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b expected 0", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.rsp_tag !== 4'd8 || bus.rsp_data !== fake_core(2'd2, k, bd) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL blocker_rsp: got tag=%0d data=%h busy=%b expected 8/%h/1",
               bus.rsp_tag, bus.rsp_data, busy, fake_core(2'd2, k, bd));
    end
    handshake();  // pop in this cycle
    tick();       // issue cycle
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (bus.core_start !== 1'b1 || bus.core_func !== 2'd3 || bus.core_data !== d[i]) begin
        n_fail++;
        $display("FAIL b2b_issue_%0d: got start=%b func=%0d data=%h expected 1/3/%h",
                 i, bus.core_start, bus.core_func, bus.core_data, d[i]);
      end
      pulse_done(int'($urandom_range(1, 3)), fake_core(2'd3, k, d[i]));
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'(i) ||
          bus.rsp_data !== fake_core(2'd3, k, d[i])) begin
        n_fail++;
        $display("FAIL order_%0d: got valid=%b tag=%0d data=%h expected 1/%0d/%h",
                 i, bus.rsp_valid, bus.rsp_tag, bus.rsp_data, i, fake_core(2'd3, k, d[i]));
      end
      handshake();
      tick();
    end
    n_checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drained: got busy=%b rsp_valid=%b ready=%b expected 0/0/1",
               busy, bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_random();
    logic [1:0]   f, kl, ckl;
    logic [255:0] k;
    logic [127:0] d, exp_data;
    logic [3:0]   tag;
    bit issue, rsp, err, ok;
    for (int n = 0; n < 24; n++) begin
      f   = 2'($urandom_range(3));
      kl  = 2'($urandom_range(3));
      k   = {8{$urandom}};
      d   = {4{$urandom}};
      tag = 4'($urandom_range(15));
      model_req(f, kl, issue, rsp, err, ckl);
      exp_data = (issue && f != 2'd1) ? fake_core(f, k, d) : 128'd0;
      push_req(f, kl, k, d, tag);
      if (issue) begin
        wait_start(ok);
        n_checks++;
        if (!ok || {bus.core_func, bus.core_klen, bus.core_key, bus.core_data} !==
                   {f, ckl, k, d}) begin
          n_fail++;
          $display("FAIL rnd_issue_%0d: got ok=%0d func=%0d klen=%0d expected 1/%0d/%0d",
                   n, ok, bus.core_func, bus.core_klen, f, ckl);
        end
        pulse_done(int'($urandom_range(1, 4)), fake_core(f, k, d));
      end
      if (rsp) begin
        wait_rsp(ok);
        n_checks++;
        if (!ok || {bus.rsp_data, bus.rsp_tag, bus.rsp_err} !== {exp_data, tag, err}) begin
          n_fail++;
          $display("FAIL rnd_rsp_%0d: got ok=%0d data=%h tag=%0d err=%b expected %h/%0d/%b",
                   n, ok, bus.rsp_data, bus.rsp_tag, bus.rsp_err, exp_data, tag, err);
        end
        repeat ($urandom_range(0, 2)) tick();
        handshake();
      end
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || key_valid !== m_kv) begin
        n_fail++;
        $display("FAIL rnd_idle_%0d: got rsp_valid=%b busy=%b kv=%b expected 0/0/%b",
                 n, bus.rsp_valid, busy, key_valid, m_kv);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k;
    bit issue, rsp, err, ok;
    logic [1:0] ckl;
    int seen;
    k = {8{$urandom}};
    model_req(2'd1, 2'd2, issue, rsp, err, ckl);
    push_req(2'd1, 2'd2, k, 128'd0, 4'd1);
    wait_start(ok);
    tick();  // WAIT
    push_req(2'd2, 2'd0, k, {4{$urandom}}, 4'd2);
    n_checks++;
    if (!ok || key_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wait: got ok=%0d kv=%b busy=%b expected 1/0/1", ok, key_valid, busy);
    end
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    m_kv   = 1'b0;
    m_klen = 2'd0;
    bus.core_done   = 1'b1;
    bus.core_result = {4{$urandom}};
    tick();
    bus.core_done = 1'b0;
    seen = 0;
    repeat (3) begin
      if (bus.rsp_valid || bus.core_start) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0 || busy !== 1'b0 || key_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got activity=%0d busy=%b kv=%b ready=%b expected 0/0/0/1",
               seen, busy, key_valid, bus.req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_err_no_key();
    test_key_expand();
    test_encrypt_stall();
    test_fifo_full();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_sched.md
# aes_sched

Request scheduler for the AES datapath: accepts key-expansion, encrypt and decrypt requests over a valid/ready interface and buffers them in a parametrised FIFO. Issues them one at a time to the shared round core (key expansion, cipher and inverse-cipher engines behind a start/done interface) and returns tagged results over a valid/ready response channel. Successor to the single-shot enable/ready top level: it adds queuing, back-pressure, run-time key length (128/192/256), request tags and key-state tracking.

## Interface
Parameters:
- DEPTH, 4, request FIFO entries; power of two, ≥2
- TAGW, 4, request/response tag width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept
- req_func  in  2  0 reserved, 1 key expand, 2 encrypt, 3 decrypt
- req_klen  in  2  0=128, 1=192, 2=256, 3 reserved (used by func 1 only)
- req_key  in  256  key, left-aligned; low bits unused for shorter keys
- req_data  in  128  plaintext/ciphertext block
- req_tag  in  TAGW  returned unchanged with the response
- core_start  out  1  one-cycle start pulse to round core
- core_func  out  2  function for the issued request
- core_klen  out  2  key length; request klen for func 1, stored klen otherwise
- core_key  out  256  key of the issued request
- core_data  out  128  data of the issued request
- core_done  in  1  one-cycle completion from round core
- core_result  in  128  core output, valid with core_done
- rsp_valid  out  1  response available
- rsp_ready  in  1  response accepted
- rsp_data  out  128  result; 0 for key expand and error
- rsp_tag  out  TAGW  tag of the request
- rsp_err  out  1  request rejected (see Configuration)
- key_valid  out  1  an expanded key is loaded in the core
- busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- Push when req_valid && req_ready. req_ready = (count < DEPTH); it does not depend on a same-cycle pop.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO is non-empty, pop the head into the issue register. A rejected request goes to RESP, or is dropped and the FSM stays in IDLE (see Configuration). Any other request goes to ISSUE.
- ISSUE: core_start=1 for exactly one cycle. core_func/klen/key/data are driven from the issue register, then the FSM goes to WAIT. core_* outputs stay stable from ISSUE until the end of WAIT.
- WAIT: on core_done, capture core_result (or 0 for func 1) into rsp_data and go to RESP. For func 1, also set key_valid=1 and store klen.
- RESP: rsp_valid=1. rsp_data, rsp_tag and rsp_err stay stable until rsp_ready. On the handshake, go to IDLE.
- core_done outside WAIT is ignored.
- A func-1 request clears key_valid on its pop, before issue. key_valid is set again only on that request's core_done.
- Requests complete strictly in FIFO order; one request is in flight at a time.
- FIFO read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. count = wptr − rptr.
- Push to a full FIFO: not accepted. Push and pop in the same cycle: count is unchanged.

## Timing
- Reset values: req_ready=1, core_start=0, core_func/klen/key/data=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, key_valid=0, busy=0. The FSM goes to IDLE and the FIFO is emptied.
- Push at cycle 0; pop at cycle 1 (FIFO write registered, no bypass); core_start at cycle 2; WAIT from cycle 3.
- core_done at cycle k (k≥3) gives rsp_valid at k+1.
- Error path: pop at cycle 1, rsp_valid at cycle 2.
- Back-to-back throughput: a response handshake in cycle r allows the next pop at r+1.
- Reset mid-operation discards the in-flight request and all queued requests. A late core_done is ignored because the FSM is in IDLE.

## Configuration
- AES_SCHED_ERR_EN defined:
  - func 0, klen 3 on func 1, and func 2/3 with key_valid=0 are rejected without touching the core.
  - The response carries rsp_err=1, rsp_data=0 and the request's tag.
- AES_SCHED_ERR_EN undefined:
  - func 0 is popped and dropped silently (no response).
  - klen 3 is issued as 256.
  - func 2/3 are issued regardless of key_valid.
  - rsp_err is tied to 0.

## Structure
- aes_wire package: request struct (func, klen, key, data, tag) and response struct; function and klen enums.
- aes_const package: FSM state encoding.
- Sub-module aes_sched_fifo: parametrised synchronous FIFO of the request struct (DEPTH, full/empty, count). It is also reusable for response buffering later.

## Test plan
- Reset, then check all outputs: req_ready=1, rsp_valid=0, key_valid=0, busy=0.
- Key expand (klen=0, tag=3), core_done 5 cycles after core_start → core_start at cycle 2, rsp_valid with tag 3, data 0, err 0, key_valid=1.
- After key load, encrypt data=00112233…eeff with tag 5 and core_result=69c4e0d8…c55a → rsp_data=69c4e0d8…c55a, tag 5; with rsp_ready held low 4 cycles, the response stays stable.
- Push DEPTH+1 requests with the core stalled → req_ready=0 after DEPTH pushes, the extra push is refused, then responses arrive in tag order 0..DEPTH-1.
- With AES_SCHED_ERR_EN: encrypt before any key expand → rsp_err=1, rsp_data=0 at cycle 2, core_start never asserted; without the macro, core_start pulses.
- Assert rst during WAIT, then pulse core_done → no rsp_valid, FIFO empty, key_valid=0.
